clock_sequencer: RTL and testbench

CLOCK_SEQUENCER -- requirements
Module: clock_sequencer

---
 rtl/clock_sequencer_if.sv | 28 ++
 rtl/clock_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_clock_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/clock_sequencer_if.sv
// Control/status bundle between the clock sequencer and its surroundings:
// restart request, raw PLL lock inputs, and all registered sequencer outputs.
interface clock_sequencer_if;
    logic       restart;
    logic       ext_pll_lock;
    logic       pix_pll_lock;
    logic       ext_pll_reset;
    logic       pix_pll_reset;
    logic       sensor_reset_n;
    logic       clocks_ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [2:0] state;

    // Sequencer side: consumes requests and locks, drives resets and status.
    modport master (
        input  restart, ext_pll_lock, pix_pll_lock,
        output ext_pll_reset, pix_pll_reset, sensor_reset_n,
               clocks_ready, fault, retry_count, state
    );

    // Environment side: the mirror image of the sequencer.
    modport slave (
        output restart, ext_pll_lock, pix_pll_lock,
        input  ext_pll_reset, pix_pll_reset, sensor_reset_n,
               clocks_ready, fault, retry_count, state
    );
endinterface

// File: rtl/clock_sequencer.sv
// Power-up clock sequencer: brings up the EXTCLK PLL, cycles the image
// sensor reset, then brings up the pixel PLL. Lock losses retry from the
// right point; too many failed attempts park the block in FAULT.
module clock_sequencer #(
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_FILTER        = 8,
    parameter int unsigned LOCK_TIMEOUT       = 65535,
    parameter int unsigned SENSOR_RST_CYCLES  = 1024,
    parameter int unsigned SENSOR_BOOT_CYCLES = 8192,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic              clk,
    input  logic              reset,
    clock_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        RST_EXT     = 3'd0,
        WAIT_EXT    = 3'd1,
        SENSOR_RST  = 3'd2,
        SENSOR_BOOT = 3'd3,
        RST_PIX     = 3'd4,
        WAIT_PIX    = 3'd5,
        RUN         = 3'd6,
        FAULT       = 3'd7
    } state_t;

    typedef struct packed {
        logic ext_pll_reset;
        logic pix_pll_reset;
        logic sensor_reset_n;
        logic clocks_ready;
        logic fault;
    } outs_t;

    // The dwell counter only has to reach the longest terminal count.
    localparam int unsigned MAX_A     = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_B     = (SENSOR_RST_CYCLES > SENSOR_BOOT_CYCLES) ? SENSOR_RST_CYCLES : SENSOR_BOOT_CYCLES;
    localparam int unsigned DWELL_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned DW        = $clog2(DWELL_MAX + 1);
    localparam int unsigned FW        = $clog2(LOCK_FILTER + 1);

    // Terminal counts: a state lasting N cycles leaves when dwell == N-1.
    localparam logic [DW-1:0] PLL_LAST     = DW'(PLL_RST_CYCLES - 1);
    localparam logic [DW-1:0] TIMEOUT_LAST = DW'(LOCK_TIMEOUT - 1);
    localparam logic [DW-1:0] SRST_LAST    = DW'(SENSOR_RST_CYCLES - 1);
    localparam logic [DW-1:0] BOOT_LAST    = DW'(SENSOR_BOOT_CYCLES - 1);
    localparam logic [FW-1:0] FILTER_LAST  = FW'(LOCK_FILTER - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t        state;
    state_t        next_state;
    state_t        retry_target;
    logic          do_retry;
    logic          entering;
    logic [3:0]    retry_count;
    logic [3:0]    next_retry;
    logic [DW-1:0] dwell;
    outs_t         outs;

    logic          ext_meta, ext_sync;
    logic          pix_meta, pix_sync;
    logic [FW-1:0] ext_filt, pix_filt;
    logic          ext_ok, pix_ok;

    // Output levels are a pure function of the state being entered; they
    // are registered alongside the state so nothing reaches a pin through
    // combinational decode.
    function automatic outs_t decode(state_t s);
        outs_t o;
        o.ext_pll_reset  = (s == RST_EXT) || (s == FAULT);
        o.pix_pll_reset  = !((s == WAIT_PIX) || (s == RUN));
        o.sensor_reset_n = (s == SENSOR_BOOT) || (s == RST_PIX) ||
                           (s == WAIT_PIX) || (s == RUN);
        o.clocks_ready   = (s == RUN);
        o.fault          = (s == FAULT);
        return o;
    endfunction

    // Two-flop synchronizers for the asynchronous PLL lock inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_meta <= 1'b0;
            ext_sync <= 1'b0;
            pix_meta <= 1'b0;
            pix_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the old
            // value of its neighbour, which is what makes this a 2-stage chain.
            ext_meta <= bus.ext_pll_lock;
            ext_sync <= ext_meta;
            pix_meta <= bus.pix_pll_lock;
            pix_sync <= pix_meta;
        end
    end

    // Lock filters: count prior consecutive synced-high cycles, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_filt <= '0;
            pix_filt <= '0;
        end else begin
            if (!ext_sync)                   ext_filt <= '0;
            else if (ext_filt != FILTER_LAST) ext_filt <= ext_filt + 1'b1;
            if (!pix_sync)                   pix_filt <= '0;
            else if (pix_filt != FILTER_LAST) pix_filt <= pix_filt + 1'b1;
        end
    end

    // A lock is accepted on the LOCK_FILTER-th consecutive synced-high cycle.
    assign ext_ok = ext_sync && (ext_filt == FILTER_LAST);
    assign pix_ok = pix_sync && (pix_filt == FILTER_LAST);

    // Next-state, retry and restart decisions in priority order.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        next_state   = state;
        next_retry   = retry_count;
        retry_target = RST_EXT;
        do_retry     = 1'b0;

        case (state)
            RST_EXT: begin
                if (dwell == PLL_LAST) next_state = WAIT_EXT;
            end
            WAIT_EXT: begin
                if (ext_ok)                    next_state = SENSOR_RST;
                else if (dwell == TIMEOUT_LAST) do_retry  = 1'b1;
            end
            SENSOR_RST: begin
                if (!ext_sync)              do_retry   = 1'b1;
                else if (dwell == SRST_LAST) next_state = SENSOR_BOOT;
            end
            SENSOR_BOOT: begin
                if (!ext_sync)              do_retry   = 1'b1;
                else if (dwell == BOOT_LAST) next_state = RST_PIX;
            end
            RST_PIX: begin
                if (!ext_sync)             do_retry   = 1'b1;
                else if (dwell == PLL_LAST) next_state = WAIT_PIX;
            end
            WAIT_PIX: begin
                if (!ext_sync) begin
                    do_retry = 1'b1;
                end else if (pix_ok) begin
                    next_state = RUN;
                end else if (dwell == TIMEOUT_LAST) begin
                    do_retry     = 1'b1;
                    retry_target = RST_PIX;
                end
            end
            RUN: begin
                // Ext loss wins when both locks drop together.
                if (!ext_sync) begin
                    do_retry = 1'b1;
                end else if (!pix_sync) begin
                    do_retry     = 1'b1;
                    retry_target = RST_PIX;
                end
            end
            FAULT: begin
                next_state = FAULT;
            end
        endcase

        if (do_retry) begin
            if (retry_count == RETRY_LIMIT) begin
                next_state = FAULT;
            end else begin
                next_state = retry_target;
                next_retry = (retry_count == 4'hF) ? retry_count : retry_count + 4'd1;
            end
        end

        if ((next_state == RUN) && (state != RUN)) next_retry = 4'd0;

        if (bus.restart) begin
            next_state = RST_EXT;
            next_retry = 4'd0;
        end

        // A retry or restart into the current state still counts as an entry.
        entering = bus.restart || do_retry || (next_state != state);
    end

    // Sequencer registers: state, dwell counter, retry count and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RST_EXT;
            dwell       <= '0;
            retry_count <= 4'd0;
            outs        <= decode(RST_EXT);
        end else begin
            state       <= next_state;
            retry_count <= next_retry;
            outs        <= decode(next_state);
            if (entering)          dwell <= '0;
            else if (dwell != '1)  dwell <= dwell + 1'b1;
        end
    end

    assign bus.ext_pll_reset  = outs.ext_pll_reset;
    assign bus.pix_pll_reset  = outs.pix_pll_reset;
    assign bus.sensor_reset_n = outs.sensor_reset_n;
    assign bus.clocks_ready   = outs.clocks_ready;
    assign bus.fault          = outs.fault;
    assign bus.retry_count    = retry_count;
    assign bus.state          = state;

endmodule

// File: tb/tb_clock_sequencer.sv
// Directed bench for clock_sequencer with short timing parameters:
// bring-up, pixel and dual lock loss, glitch filter, timeouts into FAULT,
// restart, and asynchronous reset mid-sequence.
module tb_clock_sequencer;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    clock_sequencer_if sif();

    clock_sequencer #(
        .PLL_RST_CYCLES     (4),
        .LOCK_FILTER        (4),
        .LOCK_TIMEOUT       (100),
        .SENSOR_RST_CYCLES  (10),
        .SENSOR_BOOT_CYCLES (20),
        .MAX_RETRIES        (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a sequence stalls somewhere unexpected.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Advance n active edges, then settle 1 unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Count sampled cycles spent in state s (including the current one),
    // and how many of them had sensor_reset_n low. Bounded.
    task automatic count_dwell(input logic [2:0] s, output int n, output int low);
        n   = 0;
        low = 0;
        while ((sif.state == s) && (n < 400)) begin
            n++;
            if (!sif.sensor_reset_n) low++;
            tick(1);
        end
    endtask

    task automatic dwell_is(input string tag, input logic [2:0] s, input int exp);
        int n, low;
        count_dwell(s, n, low);
        check(tag, n, exp);
    endtask

    initial begin
        int n, low;
        vectors          = 0;
        miscompares      = 0;
        reset            = 1'b1;
        sif.restart      = 1'b0;
        sif.ext_pll_lock = 1'b0;
        sif.pix_pll_lock = 1'b0;

        // ---- Reset values ----
        tick(2);
        check("rst_state",   sif.state, 0);
        check("rst_ext_rst", sif.ext_pll_reset, 1);
        check("rst_pix_rst", sif.pix_pll_reset, 1);
        check("rst_sensor",  sif.sensor_reset_n, 0);
        check("rst_ready",   sif.clocks_ready, 0);
        check("rst_fault",   sif.fault, 0);
        check("rst_retry",   sif.retry_count, 0);
        reset = 1'b0;

        // ---- Nominal bring-up ----
        dwell_is("nom_rst_ext_len", 0, 4);
        check("nom_wait_ext_pll", sif.ext_pll_reset, 0);
        check("nom_wait_ext_sensor", sif.sensor_reset_n, 0);
        tick(5);
        sif.ext_pll_lock = 1'b1;
        dwell_is("nom_ext_lock_latency", 1, 6);
        count_dwell(2, n, low);
        check("nom_sensor_rst_len", n, 10);
        check("nom_sensor_low_cycles", low, 10);
        check("nom_boot_sensor", sif.sensor_reset_n, 1);
        dwell_is("nom_boot_len", 3, 20);
        check("nom_rst_pix_pll", sif.pix_pll_reset, 1);
        dwell_is("nom_rst_pix_len", 4, 4);
        check("nom_wait_pix_pll", sif.pix_pll_reset, 0);
        tick(5);
        sif.pix_pll_lock = 1'b1;
        dwell_is("nom_pix_lock_latency", 5, 6);
        check("nom_run_state", sif.state, 6);
        check("nom_run_ready", sif.clocks_ready, 1);
        check("nom_run_retry", sif.retry_count, 0);
        check("nom_run_sensor", sif.sensor_reset_n, 1);

        // ---- Pixel lock loss in RUN ----
        sif.pix_pll_lock = 1'b0;
        tick(2);
        check("pixloss_still_run", sif.clocks_ready, 1);
        tick(1);
        check("pixloss_state",  sif.state, 4);
        check("pixloss_sensor", sif.sensor_reset_n, 1);
        check("pixloss_retry",  sif.retry_count, 1);
        check("pixloss_ready",  sif.clocks_ready, 0);
        dwell_is("pixloss_rst_pix_len", 4, 4);
        tick(5);
        sif.pix_pll_lock = 1'b1;
        dwell_is("relock_latency", 5, 6);
        check("relock_state", sif.state, 6);
        check("relock_retry", sif.retry_count, 0);

        // ---- Both locks drop together: ext retry wins ----
        sif.ext_pll_lock = 1'b0;
        sif.pix_pll_lock = 1'b0;
        tick(3);
        check("bothloss_state",  sif.state, 0);
        check("bothloss_sensor", sif.sensor_reset_n, 0);
        check("bothloss_retry",  sif.retry_count, 1);
        check("bothloss_ready",  sif.clocks_ready, 0);

        // ---- Rerun with a one-cycle glitch on pixel lock ----
        dwell_is("glitch_rst_ext_len", 0, 4);
        tick(5);
        sif.ext_pll_lock = 1'b1;
        dwell_is("glitch_ext_latency", 1, 6);
        dwell_is("glitch_sensor_rst_len", 2, 10);
        dwell_is("glitch_boot_len", 3, 20);
        dwell_is("glitch_rst_pix_len", 4, 4);
        sif.pix_pll_lock = 1'b1;
        tick(3);
        sif.pix_pll_lock = 1'b0;
        tick(1);
        sif.pix_pll_lock = 1'b1;
        tick(2);
        check("glitch_not_accepted", sif.state, 5);
        tick(3);
        check("glitch_still_waiting", sif.state, 5);
        tick(1);
        check("glitch_run_state", sif.state, 6);
        check("glitch_run_retry", sif.retry_count, 0);

        // ---- Restart, then ext lock never arrives: timeouts into FAULT ----
        sif.restart      = 1'b1;
        sif.ext_pll_lock = 1'b0;
        sif.pix_pll_lock = 1'b0;
        tick(1);
        sif.restart = 1'b0;
        check("restart_state", sif.state, 0);
        check("restart_ready", sif.clocks_ready, 0);
        check("restart_retry", sif.retry_count, 0);
        for (int k = 1; k <= 2; k++) begin
            dwell_is("to_rst_ext_len", 0, 4);
            dwell_is("to_wait_ext_len", 1, 100);
            check("to_retry_state", sif.state, 0);
            check("to_retry_count", sif.retry_count, k);
        end
        dwell_is("to_rst_ext_len_last", 0, 4);
        dwell_is("to_wait_ext_len_last", 1, 100);
        check("fault_state",   sif.state, 7);
        check("fault_flag",    sif.fault, 1);
        check("fault_ext_rst", sif.ext_pll_reset, 1);
        check("fault_pix_rst", sif.pix_pll_reset, 1);
        check("fault_sensor",  sif.sensor_reset_n, 0);
        check("fault_retry",   sif.retry_count, 2);
        tick(5);
        check("fault_sticky", sif.state, 7);
        sif.restart = 1'b1;
        tick(1);
        sif.restart = 1'b0;
        check("fault_restart_state", sif.state, 0);
        check("fault_restart_flag",  sif.fault, 0);
        check("fault_restart_retry", sif.retry_count, 0);

        // ---- Async reset while in SENSOR_BOOT ----
        dwell_is("ar_rst_ext_len", 0, 4);
        tick(5);
        sif.ext_pll_lock = 1'b1;
        dwell_is("ar_ext_latency", 1, 6);
        dwell_is("ar_sensor_rst_len", 2, 10);
        tick(5);
        check("ar_in_boot", sif.state, 3);
        #3;
        reset = 1'b1;
        sif.ext_pll_lock = 1'b0;
        #1;
        check("ar_state",   sif.state, 0);
        check("ar_ext_rst", sif.ext_pll_reset, 1);
        check("ar_pix_rst", sif.pix_pll_reset, 1);
        check("ar_sensor",  sif.sensor_reset_n, 0);
        check("ar_ready",   sif.clocks_ready, 0);
        check("ar_fault",   sif.fault, 0);
        check("ar_retry",   sif.retry_count, 0);
        tick(2);
        reset = 1'b0;
        dwell_is("ar_rerun_rst_ext_len", 0, 4);
        tick(5);
        sif.ext_pll_lock = 1'b1;
        dwell_is("ar_rerun_ext_latency", 1, 6);
        dwell_is("ar_rerun_sensor_rst_len", 2, 10);
        check("ar_rerun_boot", sif.state, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
